// File: rtl/tone_sequencer_pkg.sv
// Shared types and constants for the tone sequencer.
// Holds the state enum, phase increment table, default pattern and midscale.
package tone_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NOTE = 2'd1,
        REST = 2'd2
    } state_t;

    localparam logic [15:0] MIDSCALE = 16'h8000;
    localparam logic [7:0]  ENV_MAX  = 8'hFF;

    // Entry 1 is a quarter-rate test tone; 2..15 are C4..B5 at ~50 kHz.
    localparam logic [15:1][15:0] INC_TABLE = {
        16'd1295, 16'd1153, 16'd1028, 16'd915,
        16'd864,  16'd769,  16'd686,  16'd647,
        16'd577,  16'd514,  16'd457,  16'd432,
        16'd385,  16'd343,  16'h4000
    };

    // Nibble i is the note played at step i; 0 is a rest.
    localparam logic [15:0][3:0] DEF_PATTERN = 64'h0A0B_3C02_5070_8401;

    function automatic logic [15:0] inc_of(input logic [3:0] n);
        logic [15:0] r;
        r = '0;
        if (n != 4'd0) r = INC_TABLE[n];
        return r;
    endfunction

endpackage

// File: rtl/tone_sequencer_if.sv
// Control and audio bundle between the sequencer and its user.
// master drives play/tempo; slave (the sequencer) drives the sample side.
interface tone_sequencer_if;

    logic        play;
    logic [1:0]  tempo;
    logic [15:0] sample;
    logic        sample_stb;
    logic [3:0]  step_idx;
    logic        busy;

    modport master (
        output play, tempo,
        input  sample, sample_stb, step_idx, busy
    );

    modport slave (
        input  play, tempo,
        output sample, sample_stb, step_idx, busy
    );

endinterface

// File: rtl/tone_sequencer_sample_tick_div.sv
// Audio sample-rate divider: counts 0..CLK_DIV-1 and wraps.
// Ports: clk, rst_n (async, active low), tick (high in the last count cycle).
module sample_tick_div #(
    parameter int unsigned CLK_DIV = 800
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    logic [9:0] cnt;

    assign tick = (cnt == 10'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 10'd1;
        end
    end

endmodule

// File: rtl/tone_sequencer.sv
// Pattern-driven square-wave tone sequencer producing 16-bit audio samples.
// Ports: clk, rst_n, bus (slave: play, tempo in; sample, sample_stb, step_idx,
// busy out). Macro TONE_SEQUENCER_ENVELOPE_EN enables the decaying envelope.
module tone_sequencer
    import tone_sequencer_pkg::*;
#(
    parameter int unsigned      CLK_DIV = 800,
    parameter logic [15:0][3:0] PATTERN = DEF_PATTERN
) (
    input  logic           clk,
    input  logic           rst_n,
    tone_sequencer_if.slave bus
);

    logic        tick;
    state_t      state;
    logic [15:0] phase;
    logic [12:0] scnt;
    logic [1:0]  tempo_q;
    logic [15:0] sample_q;
    logic        stb_q;
    logic [3:0]  step_q;
    logic        busy_q;
    logic [7:0]  env;

    sample_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    logic        start;
    logic        stop;
    logic        run_tick;
    logic        step_end;
    logic [13:0] step_len;
    logic [3:0]  cur_note;
    logic [3:0]  nxt_step;
    logic [3:0]  nxt_note;
    logic [15:0] phase_nxt;
    logic [15:0] amp;

    assign start     = tick && (state == IDLE) && bus.play;
    assign stop      = tick && (state != IDLE) && !bus.play;
    assign run_tick  = tick && (state != IDLE) && bus.play;
    assign step_len  = 14'd1024 << tempo_q;
    assign step_end  = (scnt == 13'(step_len - 14'd1));
    assign cur_note  = PATTERN[step_q];
    assign nxt_step  = step_q + 4'd1;
    assign nxt_note  = PATTERN[nxt_step];
    assign phase_nxt = phase + inc_of(cur_note);
    assign amp       = {1'b0, env, 7'b0};

`ifdef TONE_SEQUENCER_ENVELOPE_EN
    logic [3:0] ecnt;

    // One decrement per 16 note ticks; reloads whenever a step begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            env  <= ENV_MAX;
            ecnt <= '0;
        end else if (start || stop || (run_tick && step_end)) begin
            env  <= ENV_MAX;
            ecnt <= '0;
        end else if (run_tick && state == NOTE) begin
            ecnt <= ecnt + 4'd1;
            if (ecnt == 4'hF && env != 8'h00) env <= env - 8'd1;
        end
    end
`else
    assign env = ENV_MAX;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            phase    <= '0;
            scnt     <= '0;
            tempo_q  <= '0;
            sample_q <= MIDSCALE;
            stb_q    <= 1'b0;
            step_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            stb_q <= tick;
            unique case (1'b1)
                start: begin
                    state   <= (PATTERN[0] != 4'd0) ? NOTE : REST;
                    busy_q  <= 1'b1;
                    scnt    <= '0;
                    step_q  <= '0;
                    tempo_q <= bus.tempo;
                end
                stop: begin
                    state    <= IDLE;
                    busy_q   <= 1'b0;
                    phase    <= '0;
                    scnt     <= '0;
                    step_q   <= '0;
                    sample_q <= MIDSCALE;
                end
                run_tick: begin
                    if (state == NOTE) begin
                        phase    <= phase_nxt;
                        sample_q <= phase_nxt[15] ? MIDSCALE + amp
                                                  : MIDSCALE - amp;
                    end else begin
                        sample_q <= MIDSCALE;
                    end
                    if (step_end) begin
                        scnt    <= '0;
                        step_q  <= nxt_step;
                        tempo_q <= bus.tempo;
                        state   <= (nxt_note != 4'd0) ? NOTE : REST;
                    end else begin
                        scnt <= scnt + 13'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sample     = sample_q;
    assign bus.sample_stb = stb_q;
    assign bus.step_idx   = step_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer with a tick-level behavioural model.
// Exercises idle, note/rest playback, step wrap, stop-on-boundary, reset.
module tb_tone_sequencer;

    import tone_sequencer_pkg::*;

    localparam int DIV = 4;
    localparam logic [15:0][3:0] PAT = 64'h0A0B_3C02_5070_8401;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    tone_sequencer_if bus();

    tone_sequencer #(
        .CLK_DIV(DIV),
        .PATTERN(PAT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: cycles since last tick, whether playing, current step,
    // ticks elapsed in the step, step length, phase accumulator.
    int m_cyc = 0;
    int m_run = 0;
    int m_step = 0;
    int m_age = 0;
    int m_len = 1024;
    int m_phase = 0;
    int exp_sample = 32768;
    int exp_stb = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pat_at(input int s);
        return int'(PAT[s]);
    endfunction

    function automatic int inc(input int n);
        int r;
        r = 0;
        if (n != 0) r = int'(INC_TABLE[n]);
        return r;
    endfunction

    // Envelope level used on the tick after 'age' ticks of a note.
    function automatic int env_at(input int age);
`ifdef TONE_SEQUENCER_ENVELOPE_EN
        int e;
        e = 255 - age / 16;
        return (e < 0) ? 0 : e;
`else
        return 255 + 0 * age;
`endif
    endfunction

    task automatic model_tick();
        int n;
        int a;
        if (m_run == 0) begin
            if (bus.play) begin
                m_run  = 1;
                m_step = 0;
                m_age  = 0;
                m_len  = 1024 << bus.tempo;
            end
        end else if (!bus.play) begin
            m_run      = 0;
            m_step     = 0;
            m_age      = 0;
            m_phase    = 0;
            exp_sample = 32768;
        end else begin
            n = pat_at(m_step);
            if (n != 0) begin
                m_phase = (m_phase + inc(n)) % 65536;
                a = env_at(m_age) * 128;
                exp_sample = (m_phase >= 32768) ? 32768 + a : 32768 - a;
            end else begin
                exp_sample = 32768;
            end
            m_age++;
            if (m_age == m_len) begin
                m_age  = 0;
                m_step = (m_step + 1) % 16;
                m_len  = 1024 << bus.tempo;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc = 0; m_run = 0; m_step = 0; m_age = 0;
            m_phase = 0; exp_sample = 32768; exp_stb = 0;
        end else begin
            exp_stb = (m_cyc == DIV - 1) ? 1 : 0;
            if (exp_stb == 1) begin
                model_tick();
                m_cyc = 0;
            end else begin
                m_cyc++;
            end
        end
    end

    always @(negedge clk) begin
        check("sample", int'(bus.sample), exp_sample);
        check("sample_stb", int'(bus.sample_stb), exp_stb);
        check("step_idx", int'(bus.step_idx), m_step);
        check("busy", int'(bus.busy), m_run);
    end

    task automatic wait_stb();
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!bus.sample_stb && c < 3 * DIV);
        if (!bus.sample_stb) check("stb_timeout", 0, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sample"}, int'(bus.sample), 32'h8000);
        check({tag, "_stb"}, int'(bus.sample_stb), 0);
        check({tag, "_step"}, int'(bus.step_idx), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
    endtask

    initial begin
        int stbs;
        int found;
        int c;
        bus.play  = 1'b0;
        bus.tempo = 2'd0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;

        stbs = 0;
        repeat (40) begin
            @(negedge clk);
            stbs += int'(bus.sample_stb);
        end
        check("idle_stb_count", stbs, 10);
        check("idle_sample", int'(bus.sample), 32'h8000);

        bus.play = 1'b1;
        wait_stb();
        check("start_busy", int'(bus.busy), 1);
        wait_stb(); check("sq0", int'(bus.sample), 32'h0080);
        wait_stb(); check("sq1", int'(bus.sample), 32'hFF80);
        wait_stb(); check("sq2", int'(bus.sample), 32'hFF80);
        wait_stb(); check("sq3", int'(bus.sample), 32'h0080);

        for (int k = 5; k <= 16384; k++) begin
            wait_stb();
            if (k == 1023) check("step_pre", int'(bus.step_idx), 0);
            if (k == 1024) check("step_adv", int'(bus.step_idx), 1);
            if (k == 16383) check("step_15", int'(bus.step_idx), 15);
            if (k == 16384) check("step_wrap", int'(bus.step_idx), 0);
        end

        found = 0;
        for (int i = 0; i < 5000 && found == 0; i++) begin
            @(negedge clk);
            if (m_run == 1 && m_age == m_len - 1 && m_cyc == DIV - 1) begin
                bus.play = 1'b0;
                found = 1;
            end
        end
        check("boundary_found", found, 1);
        wait_stb();
        check("stop_step", int'(bus.step_idx), 0);
        check("stop_sample", int'(bus.sample), 32'h8000);
        check("stop_busy", int'(bus.busy), 0);

        bus.play = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 2999) == 0) bus.play = ~bus.play;
            if ($urandom_range(0, 199) == 0) bus.tempo = 2'($urandom_range(0, 3));
        end

        bus.play = 1'b0;
        wait_stb(); wait_stb();
        bus.play = 1'b1;
        wait_stb(); wait_stb(); wait_stb();
        check("pre_reset_busy", int'(bus.busy), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!bus.sample_stb && c < 3 * DIV);
        check("first_stb_after_reset", c, DIV);
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 Parameter CLK_DIV, default 800, meaning clk cycles per audio sample (legal range 2..1023).
REQ-002 Parameter PATTERN, default a 16x4-bit constant from the package, meaning note index per step (0 = rest).
REQ-003 clk  input  1  system clock; all logic on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 play  input  1  high = run the pattern, low = stop; sampled only on sample ticks.
REQ-006 tempo  input  2  step length = 1024 << tempo samples; sampled at step boundaries.
REQ-007 sample  output  16  unsigned audio sample, midscale 0x8000, feeds the PDM modulator.
REQ-008 sample_stb  output  1  one-cycle pulse in the cycle sample takes a new value.
REQ-009 step_idx  output  4  current pattern step.
REQ-010 busy  output  1  high whenever state is not IDLE.

Function
REQ-011 Divider counts 0..CLK_DIV-1 and wraps; tick is asserted when the count equals CLK_DIV-1; sample, phase, envelope and state update on the clock edge that ends the tick cycle; sample_stb is registered and high in the following cycle only.
REQ-012 States: IDLE, NOTE, REST; all transitions occur on ticks only.
REQ-013 IDLE: sample=0x8000, phase=0, step_idx=0; play=1 at a tick -> NOTE (PATTERN[0]!=0) or REST (PATTERN[0]==0), env=0xFF, step counter=0.
REQ-014 NOTE: each tick phase(16b) += INC_TABLE[note], wrapping mod 2^16; sample = phase[15] ? 0x8000+{env,7'b0} : 0x8000-{env,7'b0}; 16-bit arithmetic, never overflows (range 0x0080..0xFF80).
REQ-015 REST: sample=0x8000; phase holds.
REQ-016 Step counter increments per tick; at (1024<<tempo)-1 it clears, step_idx increments (15 wraps to 0), env reloads 0xFF, next state is NOTE or REST per the new step's note; phase is not reset.
REQ-017 play=0 at a tick -> IDLE in that same update, taking priority over a coincident step boundary.
REQ-018 A tempo change takes effect at the next step boundary only.
REQ-019 sample_stb pulses on every tick in every state, including IDLE.

Reset
REQ-020 While rst_n=0: state=IDLE, divider=0, phase=0, step counter=0, env=0xFF, sample=0x8000, sample_stb=0, step_idx=0, busy=0.
REQ-021 Reset asserted mid-note forces the REQ-020 values immediately; after release the first tick occurs CLK_DIV cycles later.

Configuration
REQ-022 Macro TONE_SEQUENCER_ENVELOPE_EN defined: in NOTE, env decrements by 1 every 16 ticks and saturates at 0x00.
REQ-023 Macro TONE_SEQUENCER_ENVELOPE_EN undefined: env is held constant at 0xFF and no envelope counter is built.

Structure
REQ-024 Shared package holds the state enum, INC_TABLE (15 x 16-bit phase increments, index 1..15), the default PATTERN, and MIDSCALE=16'h8000.
REQ-025 One sub-module, sample_tick_div, holds the CLK_DIV divider and outputs tick.

Verification
REQ-026 CLK_DIV=4, reset release, play=0 -> sample_stb every 4 cycles, sample=0x8000, busy=0.
REQ-027 CLK_DIV=4, PATTERN[0]=1 with INC=0x4000, play=1 -> state NOTE; square period 4 ticks; sample alternates 0x8000-0x7F80=0x0080 and 0xFF80 (envelope macro off).
REQ-028 tempo=0, play held -> step_idx advances every 1024 ticks, wraps 15->0 after 16384 ticks.
REQ-029 play dropped exactly on a step-boundary tick -> IDLE, step_idx=0, sample=0x8000 in the same update.
REQ-030 Envelope macro on -> after 160 ticks in NOTE env=0xF5; it reloads to 0xFF at the next step.
REQ-031 rst_n pulsed low mid-note -> all outputs equal REQ-020 values asynchronously, before the next clock edge.
